knn_merge_ctrl: RTL and testbench
=================================

KNN_MERGE_CTRL -- requirements
Module: knn_merge_ctrl

Interface
REQ-001 The block SHALL have parameter DIST_W, default 18, giving the distance field width.
REQ-002 The block SHALL have parameter K, default 5, giving the number of neighbours per list and in the result.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port odd_valid  input  1  odd-sorter list available.
REQ-006 The block SHALL have port odd_ready  output  1  odd list accepted when odd_valid && odd_ready at a rising edge.
REQ-007 The block SHALL have port odd_list  input  K*(DIST_W+2)  odd-sorter list.
REQ-008 The block SHALL have port even_valid  input  1  even-sorter list available.
REQ-009 The block SHALL have port even_ready  output  1  even list accepted when even_valid && even_ready at a rising edge.
REQ-010 The block SHALL have port even_list  input  K*(DIST_W+2)  even-sorter list.
REQ-011 The block SHALL have port res_valid  output  1  result available.
REQ-012 The block SHALL have port res_ready  input  1  result consumed when res_valid && res_ready at a rising edge.
REQ-013 The block SHALL have port res_topk  output  K*(DIST_W+2)  merged best-K list.
REQ-014 The block SHALL have port res_class  output  2  majority-vote class.
REQ-015 The block SHALL have port busy  output  1  high in MERGE and VOTE.
REQ-016 Each list entry SHALL be {dist[DIST_W-1:0], class[1:0]}, with entry i at bits [(i+1)*(DIST_W+2)-1 : i*(DIST_W+2)]; entry 0 is nearest, and input lists are ascending by dist.

Function
REQ-017 The FSM SHALL have exactly four states: COLLECT, MERGE, VOTE, OUT.
REQ-018 In COLLECT, odd_ready SHALL equal 1 while the odd list is not yet captured, and even_ready likewise; both ready signals SHALL be 0 in all other states.
REQ-019 The two lists SHALL be captured independently, in either order or on the same edge.
REQ-020 On the edge where the second list is captured (or both lists together), the FSM SHALL go to MERGE with odd pointer po=0, even pointer pe=0 and slot counter n=0.
REQ-021 Each MERGE cycle SHALL write exactly one entry to slot n, increment n, and advance only the pointer of the list that supplied the entry.
REQ-022 MERGE selection SHALL pick odd[po] if odd.dist <= even.dist; a tie SHALL go to odd.
REQ-023 MERGE selection SHALL take the other list unconditionally once a pointer reaches K.
REQ-024 After K MERGE cycles, the FSM SHALL go to VOTE; pointers SHALL never exceed K.
REQ-025 Distance comparison SHALL be unsigned on the DIST_W-bit field only; class bits SHALL NOT affect ordering.
REQ-026 VOTE SHALL take one cycle: it counts the K class fields in res_topk (3-bit counters) and selects the class with the highest count.
REQ-027 A VOTE count tie SHALL be resolved in favour of the tied class whose first occurrence has the lowest slot index.
REQ-028 On leaving VOTE, the FSM SHALL go to OUT and assert res_valid.
REQ-029 Latency SHALL be: res_valid rises after the 6th rising edge following the completing capture edge (K=5: 5 merge edges plus 1 vote edge).
REQ-030 In OUT, res_valid, res_topk and res_class SHALL hold stable until res_valid && res_ready.
REQ-031 On the res_valid && res_ready edge, the block SHALL deassert res_valid, clear both captured flags and return to COLLECT.
REQ-032 res_topk and res_class SHALL keep their last values after the handshake until overwritten by the next MERGE/VOTE.
REQ-033 A list presented while its flag is set, or outside COLLECT, SHALL NOT be accepted and SHALL stall its producer.
REQ-034 Input lists SHALL NOT be checked for sortedness; an unsorted input gives an undefined order but SHALL still produce exactly K entries.

Reset
REQ-035 While rst=1, state SHALL be COLLECT and captured flags, po, pe and n SHALL be 0.
REQ-036 While rst=1, res_valid=0, busy=0, res_topk=0 and res_class=0.
REQ-037 While rst=1, odd_ready and even_ready SHALL both be 0.
REQ-038 odd_ready and even_ready SHALL be 1 from the first edge after rst falls.
REQ-039 Reset asserted mid-MERGE, VOTE or OUT SHALL abort immediately without emitting a result; partially captured lists SHALL be discarded.

Verification
REQ-040 Interleave test: odd dists {1,3,5,7,9} classes {0,0,0,0,0}, even dists {2,4,6,8,10} classes {1,1,1,1,1}, same-edge capture -> res_topk dists {1,2,3,4,5}, res_class=0 (count 3 vs 2), res_valid 6 edges after capture.
REQ-041 Exhaustion test: odd {1,2,3,4,5}, even {6,7,8,9,10} -> res_topk equals the odd list and pe stays 0.
REQ-042 Tie test: all dists 4, odd classes 2, even classes 3 -> all 5 slots from odd, res_class=2.
REQ-043 Vote tie test: merged classes {1,3,3,1,2} -> res_class=1; separately, odd captured 3 cycles before even -> odd_ready low after capture, latency counted from the even capture.
REQ-044 Backpressure test: res_ready=0 for 10 cycles -> outputs stable, both ready signals 0, held lists not accepted; on res_ready=1 the next pair is accepted on the following edge.
REQ-045 Reset test: rst pulsed on the 3rd MERGE cycle -> all outputs at reset values, no res_valid; the next list pair produces a correct result.

Source files
------------

// File: rtl/knn_merge_ctrl.sv
// Merges two ascending K-nearest-neighbour lists into the best K entries and
// takes a majority vote over their class fields.
module knn_merge_ctrl #(
  parameter int unsigned DIST_W = 18,
  parameter int unsigned K      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     odd_valid,
  output logic                     odd_ready,
  input  logic [K*(DIST_W+2)-1:0]  odd_list,
  input  logic                     even_valid,
  output logic                     even_ready,
  input  logic [K*(DIST_W+2)-1:0]  even_list,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [K*(DIST_W+2)-1:0]  res_topk,
  output logic [1:0]               res_class,
  output logic                     busy
);

  localparam int unsigned EW = DIST_W + 2;
  localparam int unsigned PW = $clog2(K + 1);
  localparam int unsigned CW = $clog2(K + 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] MERGE   = 2'd1;
  localparam logic [1:0] VOTE    = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  logic [1:0]                state, state_n;
  logic                      odd_cap, odd_cap_n, even_cap, even_cap_n;
  logic [PW-1:0]             po, po_n, pe, pe_n, n, n_n;
  logic [K-1:0][EW-1:0]      odd_q, odd_q_n, even_q, even_q_n, topk_q, topk_n;
  logic [1:0]                class_q, class_n;
  logic                      res_valid_n, busy_n, odd_ready_n, even_ready_n;

  logic                      odd_acc, even_acc, take_odd;
  logic [PW-1:0]             po_idx, pe_idx;
  logic [EW-1:0]             odd_head, even_head;
  logic [CW-1:0]             cnt [4];
  logic [CW-1:0]             best;
  logic [1:0]                vote;

  assign res_topk  = topk_q;
  assign res_class = class_q;

  // Head selection; an exhausted list always yields to the other one.
  always_comb begin
    po_idx    = (po < PW'(K)) ? po : '0;
    pe_idx    = (pe < PW'(K)) ? pe : '0;
    odd_head  = odd_q[po_idx];
    even_head = even_q[pe_idx];
    take_odd  = (pe >= PW'(K)) ||
                ((po < PW'(K)) && (odd_head[EW-1:2] <= even_head[EW-1:2]));
  end

  // Class histogram; strict '>' while scanning slots in order keeps the
  // earliest-occurring class on a count tie.
  always_comb begin
    for (int c = 0; c < 4; c++) cnt[c] = '0;
    for (int i = 0; i < int'(K); i++) cnt[topk_q[i][1:0]] = cnt[topk_q[i][1:0]] + CW'(1);
    best = '0;
    vote = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (cnt[topk_q[i][1:0]] > best) begin
        best = cnt[topk_q[i][1:0]];
        vote = topk_q[i][1:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    odd_cap_n  = odd_cap;
    even_cap_n = even_cap;
    po_n       = po;
    pe_n       = pe;
    n_n        = n;
    odd_q_n    = odd_q;
    even_q_n   = even_q;
    topk_n     = topk_q;
    class_n    = class_q;
    odd_acc    = (state == COLLECT) && !odd_cap && odd_valid && odd_ready;
    even_acc   = (state == COLLECT) && !even_cap && even_valid && even_ready;

    case (state)
      COLLECT: begin
        if (odd_acc) begin
          odd_cap_n = 1'b1;
          odd_q_n   = odd_list;
        end
        if (even_acc) begin
          even_cap_n = 1'b1;
          even_q_n   = even_list;
        end
        if (odd_cap_n && even_cap_n) begin
          state_n = MERGE;
          po_n    = '0;
          pe_n    = '0;
          n_n     = '0;
        end
      end
      MERGE: begin
        topk_n[n] = take_odd ? odd_head : even_head;
        n_n       = n + PW'(1);
        if (take_odd) po_n = po + PW'(1);
        else          pe_n = pe + PW'(1);
        if (n == PW'(K - 1)) state_n = VOTE;
      end
      VOTE: begin
        class_n = vote;
        state_n = OUT;
      end
      OUT: begin
        if (res_valid && res_ready) begin
          state_n    = COLLECT;
          odd_cap_n  = 1'b0;
          even_cap_n = 1'b0;
        end
      end
      default: state_n = COLLECT;
    endcase

    res_valid_n  = (state_n == OUT);
    busy_n       = (state_n == MERGE) || (state_n == VOTE);
    odd_ready_n  = (state_n == COLLECT) && !odd_cap_n;
    even_ready_n = (state_n == COLLECT) && !even_cap_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      odd_cap    <= 1'b0;
      even_cap   <= 1'b0;
      po         <= '0;
      pe         <= '0;
      n          <= '0;
      odd_q      <= '0;
      even_q     <= '0;
      topk_q     <= '0;
      class_q    <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      odd_ready  <= 1'b0;
      even_ready <= 1'b0;
    end else begin
      state      <= state_n;
      odd_cap    <= odd_cap_n;
      even_cap   <= even_cap_n;
      po         <= po_n;
      pe         <= pe_n;
      n          <= n_n;
      odd_q      <= odd_q_n;
      even_q     <= even_q_n;
      topk_q     <= topk_n;
      class_q    <= class_n;
      res_valid  <= res_valid_n;
      busy       <= busy_n;
      odd_ready  <= odd_ready_n;
      even_ready <= even_ready_n;
    end
  end

endmodule

// File: tb/tb_knn_merge_ctrl.sv
// Directed bench for knn_merge_ctrl: hand-computed merges, votes, latency,
// backpressure and mid-merge reset.
module tb_knn_merge_ctrl;
  localparam int unsigned DW = 18;
  localparam int unsigned K  = 5;
  localparam int unsigned EW = DW + 2;
  localparam int unsigned LW = K * EW;

  typedef int unsigned arr5_t [5];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          odd_valid = 1'b0, even_valid = 1'b0, res_ready = 1'b0;
  logic [LW-1:0] odd_list = '0, even_list = '0;
  logic          odd_ready, even_ready, res_valid, busy;
  logic [LW-1:0] res_topk;
  logic [1:0]    res_class;

  int passed = 0;
  int total  = 0;
  int edges;
  logic seen_valid;
  logic [LW-1:0] exp_topk;

  knn_merge_ctrl #(.DIST_W(DW), .K(K)) dut (
    .clk(clk), .rst(rst),
    .odd_valid(odd_valid), .odd_ready(odd_ready), .odd_list(odd_list),
    .even_valid(even_valid), .even_ready(even_ready), .even_list(even_list),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_topk(res_topk), .res_class(res_class), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lst(input arr5_t d, input arr5_t c);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i*EW +: EW] = {DW'(d[i]), 2'(c[i])};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until res_valid appears, bounded.
  task automatic wait_valid(output int e);
    e = 0;
    while (e < 20) begin
      step();
      e = e + 1;
      if (res_valid) break;
    end
  endtask

  task automatic present(input logic [LW-1:0] o, input logic [LW-1:0] ev);
    odd_list = o; even_list = ev; odd_valid = 1'b1; even_valid = 1'b1;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    step(); step();
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'({odd_ready, even_ready}), 128'(0));
    chk("rst_topk", 128'(res_topk), 128'(0));
    chk("rst_class", 128'(res_class), 128'(0));
    rst = 1'b0;
    step();
    chk("ready_after_rst", 128'({odd_ready, even_ready}), 128'(2'b11));

    // Interleave, same-edge capture
    present(lst('{1,3,5,7,9}, '{0,0,0,0,0}), lst('{2,4,6,8,10}, '{1,1,1,1,1}));
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    chk("il_ready_low", 128'({odd_ready, even_ready}), 128'(0));
    chk("il_busy", 128'(busy), 128'(1));
    wait_valid(edges);
    chk("il_latency", 128'(edges), 128'(6));
    chk("il_topk", 128'(res_topk), 128'(lst('{1,2,3,4,5}, '{0,1,0,1,0})));
    chk("il_class", 128'(res_class), 128'(0));
    chk("il_busy_out", 128'(busy), 128'(0));
    handshake();
    chk("il_valid_drop", 128'(res_valid), 128'(0));
    chk("il_ready_back", 128'({odd_ready, even_ready}), 128'(2'b11));
    chk("il_topk_kept", 128'(res_topk), 128'(lst('{1,2,3,4,5}, '{0,1,0,1,0})));

    // Exhaustion of the odd list
    present(lst('{1,2,3,4,5}, '{0,1,2,3,0}), lst('{6,7,8,9,10}, '{1,1,1,1,1}));
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    wait_valid(edges);
    chk("ex_latency", 128'(edges), 128'(6));
    chk("ex_topk", 128'(res_topk), 128'(lst('{1,2,3,4,5}, '{0,1,2,3,0})));
    chk("ex_class", 128'(res_class), 128'(0));
    handshake();

    // Equal distances: ties go to odd
    present(lst('{4,4,4,4,4}, '{2,2,2,2,2}), lst('{4,4,4,4,4}, '{3,3,3,3,3}));
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    wait_valid(edges);
    chk("tie_topk", 128'(res_topk), 128'(lst('{4,4,4,4,4}, '{2,2,2,2,2})));
    chk("tie_class", 128'(res_class), 128'(2));
    handshake();

    // Vote tie, odd captured three cycles ahead of even
    odd_list  = lst('{1,3,5,7,9}, '{1,3,2,0,0});
    even_list = lst('{2,4,6,8,10}, '{3,1,0,0,0});
    odd_valid = 1'b1;
    step();
    chk("vt_odd_ready_low", 128'({odd_ready, even_ready}), 128'(2'b01));
    step(); step();
    chk("vt_odd_held", 128'({odd_ready, even_ready, busy}), 128'(3'b010));
    even_valid = 1'b1;
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    wait_valid(edges);
    chk("vt_latency", 128'(edges), 128'(6));
    exp_topk = lst('{1,2,3,4,5}, '{1,3,3,1,2});
    chk("vt_topk", 128'(res_topk), 128'(exp_topk));
    chk("vt_class", 128'(res_class), 128'(1));

    // Backpressure with the next pair already offered
    present(lst('{10,20,30,40,50}, '{2,2,2,2,2}), lst('{15,25,35,45,55}, '{3,3,3,3,3}));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", 128'({res_valid, odd_ready, even_ready, busy, res_class, res_topk}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 2'd1, exp_topk}));
    end
    handshake();
    chk("bp_release", 128'({res_valid, odd_ready, even_ready}), 128'(3'b011));
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    chk("bp_accept", 128'({odd_ready, even_ready, busy}), 128'(3'b001));
    wait_valid(edges);
    chk("bp_latency", 128'(edges), 128'(6));
    chk("bp_topk", 128'(res_topk), 128'(lst('{10,15,20,25,30}, '{2,3,2,3,2})));
    chk("bp_class", 128'(res_class), 128'(2));
    handshake();

    // Reset during the third merge cycle
    present(lst('{1,3,5,7,9}, '{0,0,0,0,0}), lst('{2,4,6,8,10}, '{1,1,1,1,1}));
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("mr_outputs", 128'({res_valid, busy, odd_ready, even_ready, res_class, res_topk}), 128'(0));
    step();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (res_valid) seen_valid = 1'b1;
    end
    chk("mr_no_result", 128'(seen_valid), 128'(0));
    chk("mr_ready", 128'({odd_ready, even_ready}), 128'(2'b11));
    present(lst('{1,2,3,4,5}, '{0,1,2,3,0}), lst('{6,7,8,9,10}, '{1,1,1,1,1}));
    step();
    odd_valid = 1'b0; even_valid = 1'b0;
    wait_valid(edges);
    chk("mr_latency", 128'(edges), 128'(6));
    chk("mr_topk", 128'(res_topk), 128'(lst('{1,2,3,4,5}, '{0,1,2,3,0})));
    chk("mr_class", 128'(res_class), 128'(0));
    handshake();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
